// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Boot loader for the RISC_SPM core. It receives a byte stream over a
//   valid/ready handshake and writes program segments into SRAM. It holds the
//   processor in reset until a RUN command arrives.
//
//   Segment format:  0xA5, addr, len, data[0..len-1] [, checksum]
//   Run command:     0x5A
//   Any other command byte in IDLE is a protocol error.
//
// Configuration:
//   PROGRAM_LOADER_CHECKSUM_EN - when defined, each segment ends with a
//   checksum byte. The modular sum of addr, len, the data bytes and the
//   checksum must be zero. When undefined, the design has no CHECK state and
//   no sum register, and a segment returns straight to IDLE after its last
//   data byte.
//
// Ports:
//   clk        - single clock, rising-edge
//   rst        - asynchronous active-low reset
//   in_valid   - upstream byte available
//   in_data    - upstream byte
//   in_ready   - loader can accept a byte (registered)
//   mem_wr     - SRAM write strobe, one cycle per accepted data byte
//   mem_addr   - SRAM write address
//   mem_data   - SRAM write data
//   cpu_rst_n  - active-low processor reset, released only in RUN
//   done       - boot complete, processor released
//   err        - protocol or checksum failure (sticky until rst)
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int word_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [word_size-1:0] in_data,
    output logic                 in_ready,
    output logic                 mem_wr,
    output logic [word_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_data,
    output logic                 cpu_rst_n,
    output logic                 done,
    output logic                 err
);

    localparam logic [word_size-1:0] CMD_LOAD = word_size'(8'hA5);
    localparam logic [word_size-1:0] CMD_RUN  = word_size'(8'h5A);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_LEN,
        LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        RUN,
        ERROR
    } state_t;

    state_t               r_state;
    logic                 r_inReady;
    logic                 r_memWr;
    logic [word_size-1:0] r_memAddr;
    logic [word_size-1:0] r_memData;
    logic                 r_cpuRstN;
    logic                 r_done;
    logic                 r_err;
    logic [word_size-1:0] r_pointer;
    logic [word_size-1:0] r_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [word_size-1:0] r_sum;
    logic [word_size-1:0] w_sumNext;
`endif

    logic w_accept;

    // A byte is consumed only on an edge where both handshake signals are high.
    assign w_accept = in_valid & r_inReady;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running checksum including the byte currently offered.
    assign w_sumNext = r_sum + in_data;
`endif

    // Whole loader FSM with registered outputs. in_ready defaults to "not in
    // a terminal state". Transitions into RUN/ERROR override it to 0, so the
    // handshake closes on the same edge that the terminal state is entered.
    // mem_wr defaults to 0, so each accepted data byte gives exactly one pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_inReady <= 1'b0;
            r_memWr   <= 1'b0;
            r_memAddr <= '0;
            r_memData <= '0;
            r_cpuRstN <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_pointer <= '0;
            r_count   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_sum     <= '0;
`endif
        end else begin
            r_memWr   <= 1'b0;
            r_inReady <= (r_state != RUN) && (r_state != ERROR);

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (in_data == CMD_LOAD) begin
                            r_state <= GET_ADDR;
                        end else if (in_data == CMD_RUN) begin
                            r_state   <= RUN;
                            r_inReady <= 1'b0;
                            r_cpuRstN <= 1'b1;
                            r_done    <= 1'b1;
                        end else begin
                            r_state   <= ERROR;
                            r_inReady <= 1'b0;
                            r_err     <= 1'b1;
                        end
                    end
                end

                GET_ADDR: begin
                    if (w_accept) begin
                        r_pointer <= in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_sum     <= in_data;
`endif
                        r_state   <= GET_LEN;
                    end
                end

                GET_LEN: begin
                    if (w_accept) begin
                        r_count <= in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_sum   <= w_sumNext;
                        r_state <= (in_data == '0) ? CHECK : LOAD;
`else
                        r_state <= (in_data == '0) ? IDLE : LOAD;
`endif
                    end
                end

                // The count is never zero here, so a count of one marks the
                // last data byte of the segment.
                LOAD: begin
                    if (w_accept) begin
                        r_memWr   <= 1'b1;
                        r_memAddr <= r_pointer;
                        r_memData <= in_data;
                        r_pointer <= r_pointer + 1'b1;
                        r_count   <= r_count - 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_sum     <= w_sumNext;
                        if (r_count == word_size'(1)) begin
                            r_state <= CHECK;
                        end
`else
                        if (r_count == word_size'(1)) begin
                            r_state <= IDLE;
                        end
`endif
                    end
                end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (w_accept) begin
                        if (w_sumNext == '0) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= ERROR;
                            r_inReady <= 1'b0;
                            r_err     <= 1'b1;
                        end
                    end
                end
`endif

                RUN: begin
                    r_state <= RUN;
                end

                ERROR: begin
                    r_state <= ERROR;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign mem_wr    = r_memWr;
    assign mem_addr  = r_memAddr;
    assign mem_data  = r_memData;
    assign cpu_rst_n = r_cpuRstN;
    assign done      = r_done;
    assign err       = r_err;

endmodule
